seq_divider: RTL
================

# seq_divider

Multi-cycle restoring integer divider for the in-order pipeline's execute stage. Accepts one dividend/divisor pair through a valid/ready handshake, produces one quotient bit per cycle with a ripple subtractor, and returns quotient and remainder through a second valid/ready handshake. Supports signed and unsigned division. Divide-by-zero is flagged and takes a short path.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active-low
- in_valid  in  1  request present
- in_ready  out  1  divider can accept a request (high only in IDLE)
- is_signed  in  1  operands are two's complement
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder
- div_by_zero  out  1  divisor was zero

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: in_ready=1. On in_valid: latch operands and is_signed.
  - Divisor zero → DONE; quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise → PREP.
- PREP: form absolute values when is_signed; record neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend). Clear the partial remainder, load the iteration counter with WIDTH-1, → ITER.
- ITER: shift {rem, quo} left by 1. Trial = rem − divisor, computed as a ripple subtract.
  - Trial non-negative (carry out = 1): rem ← trial, quotient LSB ← 1.
  - Otherwise: rem unchanged, LSB ← 0.
  - When the counter reaches 0 → FIX; else decrement the counter.
- FIX: negate quotient if neg_q, negate remainder if neg_r (signed only), → DONE.
- DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready → IDLE. No new request is accepted in the same cycle.
- Arithmetic rules:
  - Absolute value of the most-negative operand is treated as an unsigned 2^(WIDTH−1).
  - Signed MIN / −1 therefore yields quotient=MIN, remainder=0, with no flag.
  - Remainder sign follows the dividend, and |remainder| < |divisor|.
- is_signed=0: operands are unsigned and no sign fix-up is applied.
- Reset values: in_ready=1 after reset, out_valid=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.

## Timing
- Accept edge = the edge where in_valid && in_ready.
- Normal path: out_valid rises WIDTH+2 edges after the accept edge (1 PREP + WIDTH ITER + 1 FIX).
- Zero-divisor path: out_valid rises on the accept edge, i.e. visible the following cycle.
- Results are registered; outputs never change while out_valid && !out_ready.
- out_valid falls on the edge where out_ready is sampled high; in_ready rises on that same edge.
- Reset low during any state: the operation is aborted on the next edge and all outputs take their reset values. No partial result is emitted.
- Operand inputs are ignored outside the accept edge.

## Structure
- Package div_pkg: state enum (div_state_e), default WIDTH constant, and the div-by-zero quotient constant (all ones).
- Sub-module div_sub_stage: WIDTH-bit ripple subtractor (a + ~b + 1) built from the team's full-adder cells. It outputs difference and carry out; carry out = 1 means no borrow.
- The top level holds the FSM, counter, remainder/quotient shift registers and sign fix-up. Use one div_sub_stage instance.
- Negation in PREP/FIX uses a two's-complement increment, not a second subtractor.

## Test plan
(Bench instantiates WIDTH=8.)
- Unsigned 100/7, out_ready=1 → quotient=14, remainder=2, div_by_zero=0, out_valid exactly 10 edges after accept.
- Signed −7/2 (0xF9/0x02) → quotient=0xFD, remainder=0xFF. Signed 7/−2 → quotient=0xFD, remainder=0x01.
- Signed −128/−1 (0x80/0xFF) → quotient=0x80, remainder=0x00, no flag. Unsigned 0x80/0xFF → quotient=0, remainder=0x80.
- Divide by zero 0x55/0x00 → quotient=0xFF, remainder=0x55, div_by_zero=1, out_valid one cycle after accept.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs unchanged and in_ready=0. Raise out_ready → in_ready=1 next cycle and back-to-back requests give correct results.
- Reset mid-ITER (reset_n low 1 cycle at edge 5) → out_valid never asserts for that request, outputs are zero, in_ready=1, and the next request 9/3 → quotient=3, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 64;

  // Divide-by-zero quotient is this bit replicated to the operand width (all ones).
  localparam logic DIV_DBZ_Q_FILL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/div_full_adder.sv
// Single-bit full-adder cell used to build the ripple subtractor.
module div_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/div_sub_stage.sv
// WIDTH-bit ripple subtractor a - b computed as a + ~b + 1; cout = 1 means no borrow.
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    div_full_adder u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed/unsigned,
// with a short path for a zero divisor.
//
// state  | meaning
// IDLE   | ready for a request; latch operands on accept
// PREP   | take absolute values, record result signs, load counter
// ITER   | shift-and-subtract, one quotient bit per cycle
// FIX    | apply sign fix-up, register results
// DONE   | result valid, held until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  div_state_e state, state_nxt;

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             sgn_q;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] quo_neg, den_neg, rem_neg;
  logic [WIDTH-1:0] rem_sh, trial;
  logic             no_borrow, take;

  assign quo_neg = ~quo_q + ONE;
  assign den_neg = ~den_q + ONE;
  assign rem_neg = ~rem_q + ONE;

  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a    (rem_sh),
    .b    (den_q),
    .diff (trial),
    .cout (no_borrow)
  );

  // The bit shifted out of rem_q is the (WIDTH+1)-th remainder bit; when set,
  // the shifted remainder exceeds any divisor and the wrapped difference is exact.
  assign take = rem_q[WIDTH-1] | no_borrow;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (divisor == '0) ? S_DONE : S_PREP;
      end
      S_PREP: state_nxt = S_ITER;
      S_ITER: if (cnt_q == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            quo_q <= dividend;
            den_q <= divisor;
            sgn_q <= is_signed;
            if (divisor == '0) begin
              quotient    <= {WIDTH{DIV_DBZ_Q_FILL}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_PREP: begin
          quo_q <= (sgn_q && quo_q[WIDTH-1]) ? quo_neg : quo_q;
          den_q <= (sgn_q && den_q[WIDTH-1]) ? den_neg : den_q;
          neg_q <= sgn_q & (quo_q[WIDTH-1] ^ den_q[WIDTH-1]);
          neg_r <= sgn_q & quo_q[WIDTH-1];
          rem_q <= '0;
          cnt_q <= CW'(WIDTH - 1);
        end
        S_ITER: begin
          rem_q <= take ? trial : rem_sh;
          quo_q <= {quo_q[WIDTH-2:0], take};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          quotient    <= neg_q ? quo_neg : quo_q;
          remainder   <= neg_r ? rem_neg : rem_q;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
